// File: rtl/fu_alg_pkg.sv
// Shared aligner constants and types: field bounds of the 163-bit aligned addend,
// the ten-bit bypass/flip select vector and the ex2 addend-control record.
package fu_alg_pkg;

  localparam int FU_ALG_BYP_LO  = 0;
  localparam int FU_ALG_BYP_HI  = 52;
  localparam int FU_ALG_PHI_HI  = 98;
  localparam int FU_ALG_LOHI_HI = 130;
  localparam int FU_ALG_LO_HI   = 162;

  localparam int FU_ALG_SEL_W = 10;

  // Bit positions inside fu_alg_sel_t (MSB first, matching the struct order).
  localparam int SEL_BYP_POS  = 9;
  localparam int SEL_BYP_NEG  = 8;
  localparam int SEL_PAS_POS  = 7;
  localparam int SEL_PAS_NEG  = 6;
  localparam int SEL_HI_POS   = 5;
  localparam int SEL_HI_NEG   = 4;
  localparam int SEL_LOHI_POS = 3;
  localparam int SEL_LOHI_NEG = 2;
  localparam int SEL_LO_POS   = 1;
  localparam int SEL_LO_NEG   = 0;

  typedef struct packed {
    logic byp_pos;   // [0:52] shifter data, true
    logic byp_neg;   // [0:52] shifter data, complemented
    logic pas_pos;   // [0:52] pass fraction, true
    logic pas_neg;   // [0:52] pass fraction, complemented
    logic hi_pos;
    logic hi_neg;
    logic lohi_pos;
    logic lohi_neg;
    logic lo_pos;
    logic lo_neg;
  } fu_alg_sel_t;

  typedef struct packed {
    logic v;
    logic neg;
    logic byp;
    logic int_op;
    logic dw;
  } fu_alg_ex2_t;

  // True when a pos/neg pair collides or field [0:52] has more than one select.
  function automatic logic fu_alg_sel_bad(input fu_alg_sel_t s);
    logic pair_hit;
    logic [2:0] f0_cnt;
    pair_hit = (s.byp_pos & s.byp_neg) | (s.pas_pos & s.pas_neg) |
               (s.hi_pos & s.hi_neg) | (s.lohi_pos & s.lohi_neg) |
               (s.lo_pos & s.lo_neg);
    f0_cnt = {2'b00, s.byp_pos} + {2'b00, s.byp_neg} +
             {2'b00, s.pas_pos} + {2'b00, s.pas_neg};
    return pair_hit | (f0_cnt > 3'd1);
  endfunction

endpackage

// File: rtl/fu_alg_bypctl_if.sv
// Addend-control bus between FU decode (master) and the bypass controller (slave).
interface fu_alg_bypctl_if;
  logic ex1_act;
  logic ex1_eff_sub;
  logic ex1_byp;
  logic ex1_int_op;
  logic ex1_int_dw;
  logic ex2_sh_ovf;
  logic ex_hold;
  logic ex2_flush;

  logic ex3_byp_sel_pos;
  logic ex3_byp_sel_neg;
  logic ex3_byp_sel_byp_pos;
  logic ex3_byp_sel_byp_neg;
  logic ex3_prd_sel_pos_hi;
  logic ex3_prd_sel_neg_hi;
  logic ex3_prd_sel_pos_lohi;
  logic ex3_prd_sel_neg_lohi;
  logic ex3_prd_sel_pos_lo;
  logic ex3_prd_sel_neg_lo;
  logic ex3_sel_err;

  modport master (
    output ex1_act, ex1_eff_sub, ex1_byp, ex1_int_op, ex1_int_dw,
           ex2_sh_ovf, ex_hold, ex2_flush,
    input  ex3_byp_sel_pos, ex3_byp_sel_neg, ex3_byp_sel_byp_pos, ex3_byp_sel_byp_neg,
           ex3_prd_sel_pos_hi, ex3_prd_sel_neg_hi, ex3_prd_sel_pos_lohi,
           ex3_prd_sel_neg_lohi, ex3_prd_sel_pos_lo, ex3_prd_sel_neg_lo, ex3_sel_err
  );

  modport slave (
    input  ex1_act, ex1_eff_sub, ex1_byp, ex1_int_op, ex1_int_dw,
           ex2_sh_ovf, ex_hold, ex2_flush,
    output ex3_byp_sel_pos, ex3_byp_sel_neg, ex3_byp_sel_byp_pos, ex3_byp_sel_byp_neg,
           ex3_prd_sel_pos_hi, ex3_prd_sel_neg_hi, ex3_prd_sel_pos_lohi,
           ex3_prd_sel_neg_lohi, ex3_prd_sel_pos_lo, ex3_prd_sel_neg_lo, ex3_sel_err
  );
endinterface

// File: rtl/fu_alg_bypctl_dec.sv
// Combinational ex2 decode of the addend control record into the ten ex3 selects.
module fu_alg_bypctl_dec
  import fu_alg_pkg::*;
(
  input  fu_alg_ex2_t ex2_i,
  input  logic        sh_ovf_i,
  output fu_alg_sel_t sel_o
);

  logic pos;
  logic neg;
  logic byp2;

  assign pos  = ~ex2_i.neg;
  assign neg  = ex2_i.neg;
  // Shift overflow only matters for FP ops; integer ops never use the shifter range.
  assign byp2 = ex2_i.byp | sh_ovf_i;

  always_comb begin
    sel_o = '0;
    if (ex2_i.v) begin
      if (ex2_i.int_op) begin
        sel_o.lohi_pos = pos & ex2_i.dw;
        sel_o.lohi_neg = neg & ex2_i.dw;
        sel_o.lo_pos   = pos;
        sel_o.lo_neg   = neg;
      end else if (byp2) begin
        sel_o.pas_pos = pos;
        sel_o.pas_neg = neg;
      end else begin
        sel_o.byp_pos  = pos;
        sel_o.byp_neg  = neg;
        sel_o.hi_pos   = pos;
        sel_o.hi_neg   = neg;
        sel_o.lohi_pos = pos;
        sel_o.lohi_neg = neg;
        sel_o.lo_pos   = pos;
        sel_o.lo_neg   = neg;
      end
    end
  end

endmodule

// File: rtl/fu_alg_bypctl.sv
// Aligner bypass/operand-flip control: ex1 decode -> ex2 record -> ex3 select registers.
// Optional one-hot checker on the ex3 selects: define FU_ALG_BYPCTL_CHK_EN.
module fu_alg_bypctl
  import fu_alg_pkg::*;
(
  input  logic nclk,
  input  logic rst_n,
  fu_alg_bypctl_if.slave bus
);

  fu_alg_ex2_t ex2_q, ex2_d;
  fu_alg_sel_t sel_q, sel_d;
  fu_alg_sel_t dec_sel;

  fu_alg_bypctl_dec u_dec (
    .ex2_i    (ex2_q),
    .sh_ovf_i (bus.ex2_sh_ovf),
    .sel_o    (dec_sel)
  );

  // Flush beats hold; under hold the ex1 op is dropped and must be re-presented.
  always_comb begin
    ex2_d = ex2_q;
    sel_d = sel_q;
    if (bus.ex2_flush) begin
      ex2_d = '0;
      sel_d = '0;
    end else if (!bus.ex_hold) begin
      ex2_d.v      = bus.ex1_act;
      ex2_d.neg    = bus.ex1_eff_sub;
      ex2_d.byp    = bus.ex1_byp;
      ex2_d.int_op = bus.ex1_int_op;
      ex2_d.dw     = bus.ex1_int_dw;
      sel_d        = dec_sel;
    end
  end

  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      ex2_q <= '0;
      sel_q <= '0;
    end else begin
      ex2_q <= ex2_d;
      sel_q <= sel_d;
    end
  end

  assign bus.ex3_byp_sel_pos      = sel_q.byp_pos;
  assign bus.ex3_byp_sel_neg      = sel_q.byp_neg;
  assign bus.ex3_byp_sel_byp_pos  = sel_q.pas_pos;
  assign bus.ex3_byp_sel_byp_neg  = sel_q.pas_neg;
  assign bus.ex3_prd_sel_pos_hi   = sel_q.hi_pos;
  assign bus.ex3_prd_sel_neg_hi   = sel_q.hi_neg;
  assign bus.ex3_prd_sel_pos_lohi = sel_q.lohi_pos;
  assign bus.ex3_prd_sel_neg_lohi = sel_q.lohi_neg;
  assign bus.ex3_prd_sel_pos_lo   = sel_q.lo_pos;
  assign bus.ex3_prd_sel_neg_lo   = sel_q.lo_neg;

`ifdef FU_ALG_BYPCTL_CHK_EN
  logic err_q, err_d;

  // Sticky: once a bad select pattern is seen at ex3 it flags until reset (ex4 timing).
  always_comb begin
    err_d = err_q | fu_alg_sel_bad(sel_q);
  end

  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.ex3_sel_err = err_q;
`else
  assign bus.ex3_sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_fu_alg_bypctl.sv
// Self-checking bench for fu_alg_bypctl: directed scenarios plus randomized traffic
// against a field-level reference model of the ex1->ex3 select pipeline.
module tb_fu_alg_bypctl;

  logic nclk;
  logic rst_n;
  int   errors;
  int   checks;

  fu_alg_bypctl_if bif ();

  fu_alg_bypctl dut (
    .nclk  (nclk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial nclk = 1'b0;
  always #5 nclk = ~nclk;

  // Reference model state: the op sitting in ex2 and the expected ex3 vector.
  bit       m_v, m_neg, m_byp, m_int, m_dw;
  bit [9:0] m_ex3;

  // Vector order: shift pos/neg, pass pos/neg, hi, lohi, lo (pos above neg).
  function automatic bit [9:0] exp_sel(bit v, bit neg, bit byp, bit io, bit dw, bit ovf);
    bit [9:0] r;
    bit [4:0] fld;   // bit f set => field f active (0 shift,1 pass,2 hi,3 lohi,4 lo)
    r = '0;
    fld = '0;
    if (v) begin
      if (io) begin
        fld[4] = 1'b1;
        fld[3] = dw;
      end else if (byp || ovf) begin
        fld[1] = 1'b1;
      end else begin
        fld = 5'b11101;
      end
    end
    for (int f = 0; f < 5; f++)
      if (fld[f]) r[9 - 2*f - (neg ? 1 : 0)] = 1'b1;
    return r;
  endfunction

  function automatic bit [9:0] got();
    return {bif.ex3_byp_sel_pos, bif.ex3_byp_sel_neg,
            bif.ex3_byp_sel_byp_pos, bif.ex3_byp_sel_byp_neg,
            bif.ex3_prd_sel_pos_hi, bif.ex3_prd_sel_neg_hi,
            bif.ex3_prd_sel_pos_lohi, bif.ex3_prd_sel_neg_lohi,
            bif.ex3_prd_sel_pos_lo, bif.ex3_prd_sel_neg_lo};
  endfunction

  task automatic drive(bit act, bit sub, bit byp, bit io, bit dw, bit ovf, bit hold, bit flush);
    bif.ex1_act     = act;
    bif.ex1_eff_sub = sub;
    bif.ex1_byp     = byp;
    bif.ex1_int_op  = io;
    bif.ex1_int_dw  = dw;
    bif.ex2_sh_ovf  = ovf;
    bif.ex_hold     = hold;
    bif.ex2_flush   = flush;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one edge, step the model with the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge nclk);
    if (!rst_n) begin
      m_v = 0; m_ex3 = '0;
    end else if (bif.ex2_flush) begin
      m_v = 0; m_ex3 = '0;
    end else if (!bif.ex_hold) begin
      m_ex3 = exp_sel(m_v, m_neg, m_byp, m_int, m_dw, bif.ex2_sh_ovf);
      m_v   = bif.ex1_act;
      m_neg = bif.ex1_eff_sub;
      m_byp = bif.ex1_byp;
      m_int = bif.ex1_int_op;
      m_dw  = bif.ex1_int_dw;
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (got() !== 10'b0) begin
      errors++; $display("FAIL reset_sel: got %b want %b", got(), 10'b0);
    end
    checks++;
    if (bif.ex3_sel_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bif.ex3_sel_err);
    end
  endtask

  task automatic test_add();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    idle(); tick();
    checks++;
    if (got() !== 10'b1000101010) begin
      errors++; $display("FAIL add_nobyp: got %b want %b", got(), 10'b1000101010);
    end
  endtask

  task automatic test_sub_ovf();
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
    checks++;
    if (got() !== 10'b0001000000) begin
      errors++; $display("FAIL sub_ovf: got %b want %b", got(), 10'b0001000000);
    end
    idle();
  endtask

  task automatic test_int();
    // word, negated; overflow must be ignored for integer ops
    drive(1, 1, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 1, 1, 1, 0, 0); tick();
    checks++;
    if (got() !== 10'b0000000001) begin
      errors++; $display("FAIL int_word_neg: got %b want %b", got(), 10'b0000000001);
    end
    drive(1, 0, 1, 1, 1, 1, 0, 0); tick();
    checks++;
    if (got() !== 10'b0000000101) begin
      errors++; $display("FAIL int_dw_neg: got %b want %b", got(), 10'b0000000101);
    end
    idle(); tick();
    checks++;
    if (got() !== 10'b0000001010) begin
      errors++; $display("FAIL int_dw_pos: got %b want %b", got(), 10'b0000001010);
    end
  endtask

  task automatic test_hold_flush();
    bit [9:0] held;
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    held = got();
    checks++;
    if (held !== 10'b0100010101) begin
      errors++; $display("FAIL hold_setup: got %b want %b", held, 10'b0100010101);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
      tick();
      checks++;
      if (got() !== 10'b0100010101) begin
        errors++; $display("FAIL hold_cycle%0d: got %b want %b", i, got(), 10'b0100010101);
      end
    end
    drive(1, 0, 0, 0, 0, 0, 1, 1); tick();
    checks++;
    if (got() !== 10'b0) begin
      errors++; $display("FAIL flush_in_hold: got %b want %b", got(), 10'b0);
    end
    // ex2 was cleared too: the next edge must still show nothing
    idle(); tick();
    checks++;
    if (got() !== 10'b0) begin
      errors++; $display("FAIL flush_ex2_dead: got %b want %b", got(), 10'b0);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 1, 0, 0, 0); tick();
    #2 rst_n = 1'b0;
    m_v = 0; m_ex3 = '0;
    #1;
    checks++;
    if (got() !== 10'b0 || bif.ex3_sel_err !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %b err %b want all 0", got(), bif.ex3_sel_err);
    end
    tick();
    #1 rst_n = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 0, 0); tick();
    idle();
    checks++;
    if (got() !== 10'b0) begin
      errors++; $display("FAIL post_reset_early: got %b want %b", got(), 10'b0);
    end
    tick();
    checks++;
    if (got() !== 10'b0100010101) begin
      errors++; $display("FAIL post_reset_op: got %b want %b", got(), 10'b0100010101);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (got() !== m_ex3) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL random_cyc%0d: got %b want %b", i, got(), m_ex3);
      end
    end
    idle();
  endtask

  task automatic test_chk();
`ifdef FU_ALG_BYPCTL_CHK_EN
    force dut.sel_q = 10'b0000110000;
    tick();
    release dut.sel_q;
    checks++;
    if (bif.ex3_sel_err !== 1'b1) begin
      errors++; $display("FAIL chk_set: got %b want 1", bif.ex3_sel_err);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1); tick(); tick(); tick();
    checks++;
    if (bif.ex3_sel_err !== 1'b1) begin
      errors++; $display("FAIL chk_sticky: got %b want 1", bif.ex3_sel_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bif.ex3_sel_err !== 1'b0) begin
      errors++; $display("FAIL chk_reset: got %b want 0", bif.ex3_sel_err);
    end
    tick();
    #1 rst_n = 1'b1;
    m_v = 0; m_ex3 = '0;
    idle();
`else
    checks++;
    if (bif.ex3_sel_err !== 1'b0) begin
      errors++; $display("FAIL chk_tied: got %b want 0", bif.ex3_sel_err);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle();
    m_v = 0; m_neg = 0; m_byp = 0; m_int = 0; m_dw = 0; m_ex3 = '0;
    tick(); tick();
    test_reset();
    #1 rst_n = 1'b1;
    test_add();
    test_sub_ovf();
    test_int();
    test_hold_flush();
    test_async_reset();
    test_random();
    test_chk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
